sdram_burst_seq: RTL and testbench

SDRAM_BURST_SEQ -- requirements
Module: sdram_burst_seq

---
 rtl/sdram_burst_seq.sv | 155 +++++++++++++++
 tb/tb_sdram_burst_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_seq.sv
// SDRAM data-path burst sequencer: write bursts with a turnaround cycle,
// read bursts after CAS latency, single-request (no queuing) front end.
module sdram_burst_seq #(
    parameter int data_size = 32,
    parameter int burst_len = 4,
    parameter int cas_lat   = 2
) (
    input  logic                 clk0_2x,
    input  logic                 reset,
    input  logic                 start_wr,
    input  logic                 start_rd,
    input  logic [data_size-1:0] wr_data,
    input  logic [data_size-1:0] sdram_in,
    output logic                 wr_data_req,
    output logic                 oe,
    output logic [data_size-1:0] datain2,
    output logic [data_size-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        TURN,
        RD_WAIT,
        RD_BURST
    } state_t;

    localparam logic [2:0] BEAT_LAST = 3'(burst_len - 1);
    localparam logic [2:0] WAIT_LAST = 3'(cas_lat - 1);

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 wr_req_q, wr_req_d;
    logic                 oe_q, oe_d;
    logic [data_size-1:0] dout_q, dout_d;
    logic [data_size-1:0] rd_q, rd_d;
    logic                 rv_q, rv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    // Next-state and next-output logic; all outputs come straight from flops.
    // WR_BURST keeps one extra cycle after the last request (wr_req_q low)
    // so the final registered beat is still driven before TURN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_req_d = wr_req_q;
        oe_d     = 1'b0;
        dout_d   = '0;
        rd_d     = rd_q;
        rv_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = busy_q & (start_wr | start_rd);
        unique case (state_q)
            IDLE: begin
                if (start_wr) begin
                    state_d  = WR_BURST;
                    cnt_d    = 3'd0;
                    wr_req_d = 1'b1;
                    busy_d   = 1'b1;
                    ovr_d    = start_rd;
                end else if (start_rd) begin
                    state_d = RD_WAIT;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                end
            end
            WR_BURST: begin
                if (wr_req_q) begin
                    oe_d   = 1'b1;
                    dout_d = wr_data;
                    if (cnt_q == BEAT_LAST) begin
                        wr_req_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = TURN;
                    done_d  = 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            RD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RD_BURST;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD_BURST: begin
                rd_d = sdram_in;
                rv_d = 1'b1;
                if (cnt_q == BEAT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in progress.
    always_ff @(posedge clk0_2x or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            wr_req_q <= 1'b0;
            oe_q     <= 1'b0;
            dout_q   <= '0;
            rd_q     <= '0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_req_q <= wr_req_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            rd_q     <= rd_d;
            rv_q     <= rv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign wr_data_req = wr_req_q;
    assign oe          = oe_q;
    assign datain2     = dout_q;
    assign rd_data     = rd_q;
    assign rd_valid    = rv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_sdram_burst_seq.sv
// Bench for sdram_burst_seq: three parameter sets share stimulus and are
// checked every cycle against a burst-schedule model; plus a directed table.
module tb_sdram_burst_seq;

    localparam int DW   = 32;
    localparam int NI   = 3;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_wr, start_rd;
    logic [DW-1:0] wr_data, sdram_in;

    logic [NI-1:0] wreq_o, oe_o, rv_o, busy_o, done_o, ovr_o;
    logic [DW-1:0] d2_o [NI];
    logic [DW-1:0] rd_o [NI];

    sdram_burst_seq #(.data_size(DW), .burst_len(4), .cas_lat(2)) u0 (
        .clk0_2x(clk), .reset(rst), .start_wr(start_wr), .start_rd(start_rd),
        .wr_data(wr_data), .sdram_in(sdram_in), .wr_data_req(wreq_o[0]),
        .oe(oe_o[0]), .datain2(d2_o[0]), .rd_data(rd_o[0]),
        .rd_valid(rv_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .overrun(ovr_o[0]));

    sdram_burst_seq #(.data_size(DW), .burst_len(1), .cas_lat(3)) u1 (
        .clk0_2x(clk), .reset(rst), .start_wr(start_wr), .start_rd(start_rd),
        .wr_data(wr_data), .sdram_in(sdram_in), .wr_data_req(wreq_o[1]),
        .oe(oe_o[1]), .datain2(d2_o[1]), .rd_data(rd_o[1]),
        .rd_valid(rv_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .overrun(ovr_o[1]));

    sdram_burst_seq #(.data_size(DW), .burst_len(8), .cas_lat(1)) u2 (
        .clk0_2x(clk), .reset(rst), .start_wr(start_wr), .start_rd(start_rd),
        .wr_data(wr_data), .sdram_in(sdram_in), .wr_data_req(wreq_o[2]),
        .oe(oe_o[2]), .datain2(d2_o[2]), .rd_data(rd_o[2]),
        .rd_valid(rv_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .overrun(ovr_o[2]));

    function automatic int bl_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int cl_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    // Expected per-cycle flags; cycle c is the interval after edge c-1.
    bit xw [NI][MAXC];
    bit xo [NI][MAXC];
    bit xv [NI][MAXC];
    bit xb [NI][MAXC];
    bit xd [NI][MAXC];
    bit xr [NI][MAXC];
    logic [DW-1:0] wd_hist [MAXC];
    logic [DW-1:0] si_hist [MAXC];
    logic [DW-1:0] rd_last [NI];

    int e;
    int tests;
    int fails;

    typedef struct {
        logic [1:0]    st;
        logic [DW-1:0] wd;
        logic [DW-1:0] si;
        logic [5:0]    fl;
        logic [DW-1:0] d2;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [28];

    task automatic cmp(input string name, input int inst,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d cycle %0d: got %h expected %h",
                     name, inst, e + 1, act, exp);
        end
    endtask

    task automatic model_clear(input int from);
        for (int i = 0; i < NI; i++) begin
            for (int c = from; c < MAXC; c++) begin
                xw[i][c] = 1'b0;
                xo[i][c] = 1'b0;
                xv[i][c] = 1'b0;
                xb[i][c] = 1'b0;
                xd[i][c] = 1'b0;
                xr[i][c] = 1'b0;
            end
            rd_last[i] = '0;
        end
    endtask

    // Schedule the consequences of the requests sampled at edge n.
    task automatic model_edge(input int n);
        for (int i = 0; i < NI; i++) begin
            int bl;
            int cl;
            bl = bl_of(i);
            cl = cl_of(i);
            if (xb[i][n]) begin
                if (start_wr || start_rd) xr[i][n+1] = 1'b1;
            end else if (start_wr) begin
                for (int k = 1; k <= bl + 2; k++) xb[i][n+k] = 1'b1;
                for (int k = 1; k <= bl; k++) xw[i][n+k] = 1'b1;
                for (int k = 2; k <= bl + 1; k++) xo[i][n+k] = 1'b1;
                xd[i][n+bl+2] = 1'b1;
                if (start_rd) xr[i][n+1] = 1'b1;
            end else if (start_rd) begin
                for (int k = 1; k <= cl + bl; k++) xb[i][n+k] = 1'b1;
                for (int k = cl + 2; k <= cl + bl + 1; k++) xv[i][n+k] = 1'b1;
                xd[i][n+cl+bl+1] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input int c);
        for (int i = 0; i < NI; i++) begin
            logic [DW-1:0] ed;
            ed = xo[i][c] ? wd_hist[c-1] : '0;
            if (xv[i][c]) rd_last[i] = si_hist[c-1];
            cmp("wr_data_req", i, DW'(wreq_o[i]), DW'(xw[i][c]));
            cmp("oe", i, DW'(oe_o[i]), DW'(xo[i][c]));
            cmp("datain2", i, d2_o[i], ed);
            cmp("rd_valid", i, DW'(rv_o[i]), DW'(xv[i][c]));
            cmp("rd_data", i, rd_o[i], rd_last[i]);
            cmp("busy", i, DW'(busy_o[i]), DW'(xb[i][c]));
            cmp("done", i, DW'(done_o[i]), DW'(xd[i][c]));
            cmp("overrun", i, DW'(ovr_o[i]), DW'(xr[i][c]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        wd_hist[e] = wr_data;
        si_hist[e] = sdram_in;
        if (!rst) model_edge(e);
        #1;
        check_all(e + 1);
    endtask

    task automatic rand_data();
        wr_data  = $urandom;
        sdram_in = $urandom;
    endtask

    task automatic set_row(input int r, input logic [1:0] st,
                           input logic [DW-1:0] wd, input logic [DW-1:0] si,
                           input logic [5:0] fl, input logic [DW-1:0] d2,
                           input logic [DW-1:0] rd);
        tbl[r].st = st;
        tbl[r].wd = wd;
        tbl[r].si = si;
        tbl[r].fl = fl;
        tbl[r].d2 = d2;
        tbl[r].rd = rd;
    endtask

    initial begin
        int n0;
        tests    = 0;
        fails    = 0;
        e        = 0;
        rst      = 1'b1;
        start_wr = 1'b0;
        start_rd = 1'b0;
        wr_data  = '0;
        sdram_in = '0;
        model_clear(0);

        // st = {start_wr,start_rd}; fl = {wreq,oe,rv,busy,done,overrun}
        set_row(0,  2'b10, 32'h0,  32'h0,  6'b100100, 32'h0,  32'h0);
        set_row(1,  2'b00, 32'hA0, 32'h0,  6'b110100, 32'hA0, 32'h0);
        set_row(2,  2'b00, 32'hA1, 32'h0,  6'b110100, 32'hA1, 32'h0);
        set_row(3,  2'b00, 32'hA2, 32'h0,  6'b110100, 32'hA2, 32'h0);
        set_row(4,  2'b00, 32'hA3, 32'h0,  6'b010100, 32'hA3, 32'h0);
        set_row(5,  2'b00, 32'h0,  32'h0,  6'b000110, 32'h0,  32'h0);
        set_row(6,  2'b00, 32'h0,  32'h0,  6'b000000, 32'h0,  32'h0);
        set_row(7,  2'b01, 32'h0,  32'h0,  6'b000100, 32'h0,  32'h0);
        set_row(8,  2'b00, 32'h0,  32'h0,  6'b000100, 32'h0,  32'h0);
        set_row(9,  2'b00, 32'h0,  32'h0,  6'b000100, 32'h0,  32'h0);
        set_row(10, 2'b00, 32'h0,  32'hB0, 6'b001100, 32'h0,  32'hB0);
        set_row(11, 2'b00, 32'h0,  32'hB1, 6'b001100, 32'h0,  32'hB1);
        set_row(12, 2'b00, 32'h0,  32'hB2, 6'b001100, 32'h0,  32'hB2);
        set_row(13, 2'b00, 32'h0,  32'hB3, 6'b001010, 32'h0,  32'hB3);
        set_row(14, 2'b10, 32'h0,  32'h0,  6'b100100, 32'h0,  32'hB3);
        set_row(15, 2'b00, 32'hC0, 32'h0,  6'b110100, 32'hC0, 32'hB3);
        set_row(16, 2'b00, 32'hC1, 32'h0,  6'b110100, 32'hC1, 32'hB3);
        set_row(17, 2'b00, 32'hC2, 32'h0,  6'b110100, 32'hC2, 32'hB3);
        set_row(18, 2'b00, 32'hC3, 32'h0,  6'b010100, 32'hC3, 32'hB3);
        set_row(19, 2'b00, 32'h0,  32'h0,  6'b000110, 32'h0,  32'hB3);
        set_row(20, 2'b00, 32'h0,  32'h0,  6'b000000, 32'h0,  32'hB3);
        set_row(21, 2'b11, 32'h0,  32'h0,  6'b100101, 32'h0,  32'hB3);
        set_row(22, 2'b01, 32'hD0, 32'h0,  6'b110101, 32'hD0, 32'hB3);
        set_row(23, 2'b00, 32'hD1, 32'h0,  6'b110100, 32'hD1, 32'hB3);
        set_row(24, 2'b00, 32'hD2, 32'h0,  6'b110100, 32'hD2, 32'hB3);
        set_row(25, 2'b00, 32'hD3, 32'h0,  6'b010100, 32'hD3, 32'hB3);
        set_row(26, 2'b00, 32'h0,  32'h0,  6'b000110, 32'h0,  32'hB3);
        set_row(27, 2'b00, 32'h0,  32'h0,  6'b000000, 32'h0,  32'hB3);

        // reset state, before and across clock edges
        #2;
        check_all(1);
        step();
        step();
        rst = 1'b0;

        // directed table on the burst_len=4, cas_lat=2 instance
        for (int r = 0; r < 28; r++) begin
            start_wr = tbl[r].st[1];
            start_rd = tbl[r].st[0];
            wr_data  = tbl[r].wd;
            sdram_in = tbl[r].si;
            step();
            cmp("tbl_wreq", r, DW'(wreq_o[0]), DW'(tbl[r].fl[5]));
            cmp("tbl_oe", r, DW'(oe_o[0]), DW'(tbl[r].fl[4]));
            cmp("tbl_datain2", r, d2_o[0], tbl[r].d2);
            cmp("tbl_rd_valid", r, DW'(rv_o[0]), DW'(tbl[r].fl[3]));
            cmp("tbl_rd_data", r, rd_o[0], tbl[r].rd);
            cmp("tbl_busy", r, DW'(busy_o[0]), DW'(tbl[r].fl[2]));
            cmp("tbl_done", r, DW'(done_o[0]), DW'(tbl[r].fl[1]));
            cmp("tbl_overrun", r, DW'(ovr_o[0]), DW'(tbl[r].fl[0]));
        end
        start_wr = 1'b0;
        start_rd = 1'b0;

        // back-to-back write->read, then read->write, on every instance
        start_wr = 1'b1;
        rand_data();
        step();
        start_wr = 1'b0;
        start_rd = 1'b1;
        repeat (25) begin rand_data(); step(); end
        start_rd = 1'b0;
        repeat (12) begin rand_data(); step(); end
        start_rd = 1'b1;
        rand_data();
        step();
        start_rd = 1'b0;
        start_wr = 1'b1;
        repeat (25) begin rand_data(); step(); end
        start_wr = 1'b0;
        repeat (15) begin rand_data(); step(); end

        // reset in the 2nd RD_BURST cycle of u0, then a fresh write
        start_rd = 1'b1;
        rand_data();
        step();
        start_rd = 1'b0;
        n0 = e;
        while (e < n0 + 3) begin rand_data(); step(); end
        #3;
        rst = 1'b1;
        model_clear(e + 1);
        #1;
        check_all(e + 1);
        step();
        step();
        rst = 1'b0;
        start_wr = 1'b1;
        rand_data();
        step();
        start_wr = 1'b0;
        repeat (12) begin rand_data(); step(); end

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            start_wr = ($urandom_range(0, 99) < 12);
            start_rd = ($urandom_range(0, 99) < 12);
            rand_data();
            step();
        end
        start_wr = 1'b0;
        start_rd = 1'b0;
        repeat (15) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
